br_recovery_ctl: RTL and testbench

- Sequences branch-mispredict recovery for the execute cluster.
- Collects t_br_mispred_pkt reports from NUM_BR branch units each cycle and selects the oldest by ROB age.
- Issues a one-cycle pipeline flush, then re-steers fetch over a valid/ready handshake, then waits for the back end to drain.
- An older mispredict arriving mid-recovery preempts the one in flight.

---
 rtl/br_recovery_ctl_pkg.sv | 24 ++
 rtl/rob_age_sel.sv | 39 +++
 rtl/br_recovery_ctl.sv | 140 ++++++++++++++
 tb/tb_br_recovery_ctl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/br_recovery_ctl_pkg.sv
// Shared types for branch-mispredict recovery: ROB ids, physical addresses,
// the per-unit mispredict report and the recovery FSM state encoding.
package br_recovery_ctl_pkg;

    localparam int BRR_ROBID_W = 6;
    localparam int PADDR_W     = 32;

    typedef logic [PADDR_W-1:0]     t_paddr;
    typedef logic [BRR_ROBID_W-1:0] t_rob_id;

    typedef struct packed {
        logic    valid;
        t_paddr  target_addr;
        t_rob_id robid;
    } t_br_mispred_pkt;

    typedef enum logic [1:0] {
        BRR_IDLE,
        BRR_FLUSH,
        BRR_RESTEER,
        BRR_DRAIN
    } t_br_recov_state;

endpackage

// File: rtl/rob_age_sel.sv
// Oldest-of-N selector: picks the valid ROB id with the smallest distance
// from the ROB head (modulo wrap); equal ages resolve to the lowest index.
module rob_age_sel #(
    parameter int N = 2,
    parameter int W = 6,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]        valids,
    input  logic [N-1:0][W-1:0] robids,
    input  logic [W-1:0]        head,
    output logic                sel_valid,
    output logic [IDX_W-1:0]    sel_idx
);

    logic [N-1:0][W-1:0] ages;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_age
            assign ages[gi] = robids[gi] - head;
        end
    endgenerate

    logic [W-1:0] best_age;

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        for (int i = 0; i < N; i++) begin
            // Strict compare keeps the earlier index on a tie.
            if (valids[i] && (!sel_valid || ages[i] < best_age)) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
                best_age  = ages[i];
            end
        end
    end

endmodule

// File: rtl/br_recovery_ctl.sv
// Branch-mispredict recovery sequencer: selects the oldest report, pulses a
// flush, re-steers fetch over valid/ready, then waits for the back end drain.
module br_recovery_ctl
    import br_recovery_ctl_pkg::*;
#(
    parameter int NUM_BR  = 2,
    parameter int ROBID_W = BRR_ROBID_W,
    parameter int CNT_W   = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  t_br_mispred_pkt [NUM_BR-1:0]       br_mispred_in,
    input  logic [ROBID_W-1:0]                 rob_head_robid,
    output logic                               flush_valid,
    output logic [ROBID_W-1:0]                 flush_robid,
    output logic                               resteer_valid,
    output t_paddr                             resteer_addr,
    input  logic                               resteer_ready,
    input  logic                               drain_done,
    output logic                               recovery_busy,
    output logic [CNT_W-1:0]                   mispred_count
);

    localparam int IDX_W = (NUM_BR > 1) ? $clog2(NUM_BR) : 1;

    logic [NUM_BR-1:0]              cand_valid;
    logic [NUM_BR-1:0][ROBID_W-1:0] cand_robid;
    logic                           sel_valid;
    logic [IDX_W-1:0]               sel_idx;

    generate
        for (genvar gi = 0; gi < NUM_BR; gi++) begin : g_cand
            assign cand_valid[gi] = br_mispred_in[gi].valid;
            assign cand_robid[gi] = br_mispred_in[gi].robid;
        end
    endgenerate

    rob_age_sel #(
        .N (NUM_BR),
        .W (ROBID_W)
    ) u_age_sel (
        .valids    (cand_valid),
        .robids    (cand_robid),
        .head      (rob_head_robid),
        .sel_valid (sel_valid),
        .sel_idx   (sel_idx)
    );

    t_br_recov_state      state_q, state_d;
    logic                 flush_valid_q, flush_valid_d;
    logic [ROBID_W-1:0]   flush_robid_q, flush_robid_d;
    logic                 resteer_valid_q, resteer_valid_d;
    t_paddr               resteer_addr_q, resteer_addr_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic [ROBID_W-1:0]   sel_robid;
    t_paddr               sel_addr;
    logic [ROBID_W-1:0]   cand_age;
    logic [ROBID_W-1:0]   cur_age;
    logic                 accept;

    assign sel_robid = cand_robid[sel_idx];
    assign sel_addr  = br_mispred_in[sel_idx].target_addr;
    assign cand_age  = sel_robid - rob_head_robid;
    assign cur_age   = flush_robid_q - rob_head_robid;

    // Mid-recovery, only a strictly older branch matters; anything younger
    // is already covered by the flush in flight.
    assign accept = sel_valid && ((state_q == BRR_IDLE) || (cand_age < cur_age));

    always_comb begin
        state_d        = state_q;
        flush_robid_d  = flush_robid_q;
        resteer_addr_d = resteer_addr_q;
        count_d        = count_q;

        unique case (state_q)
            BRR_IDLE:    state_d = BRR_IDLE;
            BRR_FLUSH:   state_d = BRR_RESTEER;
            BRR_RESTEER: if (resteer_ready) state_d = BRR_DRAIN;
            BRR_DRAIN:   if (drain_done) state_d = BRR_IDLE;
            default:     state_d = BRR_IDLE;
        endcase

        if (accept) begin
            state_d        = BRR_FLUSH;
            flush_robid_d  = sel_robid;
            resteer_addr_d = sel_addr;
            count_d        = count_q + CNT_W'(1);
        end

        flush_valid_d   = (state_d == BRR_FLUSH);
        resteer_valid_d = (state_d == BRR_RESTEER);
        busy_d          = (state_d != BRR_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= BRR_IDLE;
            flush_valid_q   <= 1'b0;
            flush_robid_q   <= '0;
            resteer_valid_q <= 1'b0;
            resteer_addr_q  <= '0;
            busy_q          <= 1'b0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            flush_valid_q   <= flush_valid_d;
            flush_robid_q   <= flush_robid_d;
            resteer_valid_q <= resteer_valid_d;
            resteer_addr_q  <= resteer_addr_d;
            busy_q          <= busy_d;
            count_q         <= count_d;
        end
    end

    assign flush_valid   = flush_valid_q;
    assign flush_robid   = flush_robid_q;
    assign resteer_valid = resteer_valid_q;
    assign resteer_addr  = resteer_addr_q;
    assign recovery_busy = busy_q;
    assign mispred_count = count_q;

    // Two live reports with the same robid means the ROB handed out a duplicate.
    logic dup_robid;
    always_comb begin
        dup_robid = 1'b0;
        for (int i = 0; i < NUM_BR; i++) begin
            for (int j = i + 1; j < NUM_BR; j++) begin
                if (cand_valid[i] && cand_valid[j] && (cand_robid[i] == cand_robid[j])) begin
                    dup_robid = 1'b1;
                end
            end
        end
    end

    a_no_dup_robid: assert property (@(posedge clk) disable iff (reset) !dup_robid);

endmodule

// File: tb/tb_br_recovery_ctl.sv
// Directed bench for br_recovery_ctl: a transaction-level recovery model is
// stepped alongside the DUT and compared every cycle, plus literal checkpoints.
module tb_br_recovery_ctl;
    import br_recovery_ctl_pkg::*;

    localparam int P_IDLE    = 0;
    localparam int P_FLUSH   = 1;
    localparam int P_RESTEER = 2;
    localparam int P_DRAIN   = 3;

    logic                  clk;
    logic                  reset;
    t_br_mispred_pkt [1:0] br_in;
    logic [5:0]            head;
    logic                  flush_valid;
    logic [5:0]            flush_robid;
    logic                  resteer_valid;
    t_paddr                resteer_addr;
    logic                  resteer_ready;
    logic                  drain_done;
    logic                  recovery_busy;
    logic [31:0]           mispred_count;

    br_recovery_ctl #(
        .NUM_BR  (2),
        .ROBID_W (6),
        .CNT_W   (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .br_mispred_in  (br_in),
        .rob_head_robid (head),
        .flush_valid    (flush_valid),
        .flush_robid    (flush_robid),
        .resteer_valid  (resteer_valid),
        .resteer_addr   (resteer_addr),
        .resteer_ready  (resteer_ready),
        .drain_done     (drain_done),
        .recovery_busy  (recovery_busy),
        .mispred_count  (mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    int     cyc    = 0;

    int     m_phase = P_IDLE;
    int     m_robid = 0;
    longint m_addr  = 0;
    longint m_count = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cyc=%0d %s: got=0x%0h expected=0x%0h", cyc, name, act, exp);
        end
    endtask

    // Recovery model: oldest report by modular age, preempt only if strictly older.
    task automatic model_step();
        int  best;
        int  bidx;
        bit  found;
        int  a;
        int  cur;
        int  np;
        if (reset) begin
            m_phase = P_IDLE; m_robid = 0; m_addr = 0; m_count = 0;
            return;
        end
        found = 0; best = 0; bidx = 0;
        for (int u = 0; u < 2; u++) begin
            if (br_in[u].valid) begin
                a = (int'(br_in[u].robid) - int'(head) + 64) % 64;
                if (!found || a < best) begin
                    found = 1; best = a; bidx = u;
                end
            end
        end
        cur = (m_robid - int'(head) + 64) % 64;
        np  = m_phase;
        if (m_phase == P_FLUSH) np = P_RESTEER;
        else if (m_phase == P_RESTEER && resteer_ready) np = P_DRAIN;
        else if (m_phase == P_DRAIN && drain_done) np = P_IDLE;
        if (found && (m_phase == P_IDLE || best < cur)) begin
            np      = P_FLUSH;
            m_robid = int'(br_in[bidx].robid);
            m_addr  = longint'(br_in[bidx].target_addr);
            m_count = (m_count + 1) & 64'hFFFF_FFFF;
        end
        m_phase = np;
    endtask

    task automatic compare_all();
        chk("flush_valid",   longint'(flush_valid),   longint'(m_phase == P_FLUSH));
        chk("resteer_valid", longint'(resteer_valid), longint'(m_phase == P_RESTEER));
        chk("recovery_busy", longint'(recovery_busy), longint'(m_phase != P_IDLE));
        chk("flush_robid",   longint'(flush_robid),   longint'(m_robid));
        chk("resteer_addr",  longint'(resteer_addr),  m_addr);
        chk("mispred_count", longint'(mispred_count), m_count);
        $display("cyc=%0d fv=%0b rob=%0d rv=%0b addr=0x%0h busy=%0b cnt=%0d",
                 cyc, flush_valid, flush_robid, resteer_valid, resteer_addr,
                 recovery_busy, mispred_count);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic put(input int u, input int r, input longint t);
        br_in[u].valid       = 1'b1;
        br_in[u].robid       = t_rob_id'(r);
        br_in[u].target_addr = t_paddr'(t);
    endtask

    task automatic clr();
        br_in = '0;
    endtask

    initial begin
        reset = 1'b1;
        br_in = '0;
        head = '0;
        resteer_ready = 1'b0;
        drain_done = 1'b0;
        tick();
        tick();
        chk("reset_busy", longint'(recovery_busy), 0);
        chk("reset_count", longint'(mispred_count), 0);
        reset = 1'b0;
        tick();

        // Single mispredict with a stalled resteer.
        put(0, 5, 64'h1000);
        tick();
        chk("single_flush_valid", longint'(flush_valid), 1);
        chk("single_flush_robid", longint'(flush_robid), 5);
        clr();
        tick();
        chk("single_resteer_valid", longint'(resteer_valid), 1);
        chk("single_flush_done", longint'(flush_valid), 0);
        tick();
        tick();
        chk("single_addr_stable", longint'(resteer_addr), 64'h1000);
        resteer_ready = 1'b1;
        tick();
        resteer_ready = 1'b0;
        tick();
        drain_done = 1'b1;
        tick();
        drain_done = 1'b0;
        chk("single_idle", longint'(recovery_busy), 0);
        chk("single_count", longint'(mispred_count), 1);

        // Simultaneous reports, best-case latency (drain_done early is ignored).
        put(0, 9, 64'h900);
        put(1, 3, 64'h300);
        tick();
        chk("simul_robid", longint'(flush_robid), 3);
        clr();
        resteer_ready = 1'b1;
        drain_done = 1'b1;
        tick();
        chk("simul_addr", longint'(resteer_addr), 64'h300);
        tick();
        tick();
        chk("simul_idle_t4", longint'(recovery_busy), 0);
        resteer_ready = 1'b0;
        drain_done = 1'b0;
        chk("simul_count", longint'(mispred_count), 2);

        // Preemption in RESTEER, then a younger report in DRAIN is dropped.
        put(0, 10, 64'hA00);
        tick();
        clr();
        tick();
        put(1, 4, 64'h400);
        tick();
        chk("preempt_flush", longint'(flush_valid), 1);
        chk("preempt_robid", longint'(flush_robid), 4);
        chk("preempt_withdraw", longint'(resteer_valid), 0);
        clr();
        tick();
        chk("preempt_addr", longint'(resteer_addr), 64'h400);
        resteer_ready = 1'b1;
        tick();
        resteer_ready = 1'b0;
        put(0, 12, 64'hC00);
        tick();
        chk("drain_drop_count", longint'(mispred_count), 4);
        chk("drain_drop_robid", longint'(flush_robid), 4);
        clr();
        drain_done = 1'b1;
        tick();
        drain_done = 1'b0;

        // Wrap-around ages, younger report during FLUSH dropped, then reset mid-RESTEER.
        head = 6'd60;
        put(0, 1, 64'h100);
        put(1, 62, 64'h6200);
        tick();
        chk("wrap_robid", longint'(flush_robid), 62);
        clr();
        put(0, 63, 64'h6300);
        tick();
        chk("wrap_resteer_addr", longint'(resteer_addr), 64'h6200);
        chk("wrap_count", longint'(mispred_count), 5);
        clr();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_rv", longint'(resteer_valid), 0);
        chk("async_rst_busy", longint'(recovery_busy), 0);
        chk("async_rst_addr", longint'(resteer_addr), 0);
        chk("async_rst_count", longint'(mispred_count), 0);
        chk("async_rst_robid", longint'(flush_robid), 0);
        model_step();
        tick();
        reset = 1'b0;
        head = '0;
        put(1, 7, 64'h700);
        tick();
        chk("post_rst_flush", longint'(flush_valid), 1);
        chk("post_rst_robid", longint'(flush_robid), 7);
        clr();
        tick();
        resteer_ready = 1'b1;
        tick();
        resteer_ready = 1'b0;
        drain_done = 1'b1;
        tick();
        drain_done = 1'b0;
        chk("final_count", longint'(mispred_count), 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
